// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: registered single-cycle logic/arith/compare ops plus iterative
// MULT/MULTU (shift-add) and DIV/DIVU (restoring) into HI/LO. Optional macro: OVERFLOW_DETECT_EN.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluOperation,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             divByZero
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
`ifdef OVERFLOW_DETECT_EN
    logic             ovf_q, ovf_d;
    logic             ovf_v;
`endif

    // Bitwise logic ops, one slice per bit.
    logic [WIDTH-1:0] and_v, or_v, nor_v;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_v[gi] = operandA[gi] & operandB[gi];
            assign or_v[gi]  = operandA[gi] | operandB[gi];
            assign nor_v[gi] = ~(operandA[gi] | operandB[gi]);
        end
    endgenerate

    logic [WIDTH-1:0] sum_v, diff_v, slt_v, simple_v;
    logic             is_mult, is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        sum_v     = operandA + operandB;
        diff_v    = operandA - operandB;
        slt_v     = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
        is_mult   = (aluOperation[3:1] == 3'b100);
        is_div    = (aluOperation[3:1] == 3'b101);
        is_signed = ~aluOperation[0];
        a_neg     = is_signed & operandA[WIDTH-1];
        b_neg     = is_signed & operandB[WIDTH-1];
        a_mag     = a_neg ? (~operandA + 1'b1) : operandA;
        b_mag     = b_neg ? (~operandB + 1'b1) : operandB;
        case (aluOperation)
            OP_AND:  simple_v = and_v;
            OP_OR:   simple_v = or_v;
            OP_ADD:  simple_v = sum_v;
            OP_SUB:  simple_v = diff_v;
            OP_SLT:  simple_v = slt_v;
            default: simple_v = nor_v;
        endcase
    end

`ifdef OVERFLOW_DETECT_EN
    always_comb begin
        case (aluOperation)
            OP_ADD:  ovf_v = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                             (sum_v[WIDTH-1] != operandA[WIDTH-1]);
            OP_SUB:  ovf_v = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                             (diff_v[WIDTH-1] != operandA[WIDTH-1]);
            default: ovf_v = 1'b0;
        endcase
    end
`endif

    // One iteration step; acc_lo holds the multiplier / dividend being shifted out.
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        mul_sum   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, b_mag_q}) : {1'b0, acc_hi_q};
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_mag_q};
        if (is_div_q) begin
            // A clear top bit means the trial subtraction did not go negative.
            step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        prod_fix = neg_q ? (~{acc_hi_q, acc_lo_q} + 1'b1) : {acc_hi_q, acc_lo_q};
        quo_fix  = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix  = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_hi_d     = acc_hi_q;
        acc_lo_d     = acc_lo_q;
        b_mag_d      = b_mag_q;
        is_div_d     = is_div_q;
        neg_d        = neg_q;
        rem_neg_d    = rem_neg_q;
        done_d       = 1'b0;
        alu_result_d = alu_result_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        zero_d       = zero_q;
        dbz_d        = dbz_q;
`ifdef OVERFLOW_DETECT_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mult || (is_div && (operandB != '0))) begin
                        state_d   = S_ITER;
                        cnt_d     = '0;
                        acc_hi_d  = '0;
                        acc_lo_d  = a_mag;
                        b_mag_d   = b_mag;
                        is_div_d  = is_div;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                    end else begin
                        done_d = 1'b1;
                        if (is_div) begin
                            // Divide by zero completes immediately with a flagged result.
                            alu_result_d = '1;
                            lo_d         = '1;
                            hi_d         = operandA;
                            zero_d       = 1'b0;
                            dbz_d        = 1'b1;
                        end else begin
                            alu_result_d = simple_v;
                            zero_d       = (simple_v == '0);
                            dbz_d        = 1'b0;
                        end
`ifdef OVERFLOW_DETECT_EN
                        ovf_d = ovf_v;
`endif
                    end
                end
            end
            S_ITER: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                if (is_div_q) begin
                    hi_d         = rem_fix;
                    lo_d         = quo_fix;
                    alu_result_d = quo_fix;
                    zero_d       = (quo_fix == '0);
                end else begin
                    hi_d         = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d         = prod_fix[WIDTH-1:0];
                    alu_result_d = prod_fix[WIDTH-1:0];
                    zero_d       = (prod_fix[WIDTH-1:0] == '0);
                end
`ifdef OVERFLOW_DETECT_EN
                ovf_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_hi_q     <= '0;
            acc_lo_q     <= '0;
            b_mag_q      <= '0;
            is_div_q     <= 1'b0;
            neg_q        <= 1'b0;
            rem_neg_q    <= 1'b0;
            done_q       <= 1'b0;
            alu_result_q <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            zero_q       <= 1'b1;
            dbz_q        <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_hi_q     <= acc_hi_d;
            acc_lo_q     <= acc_lo_d;
            b_mag_q      <= b_mag_d;
            is_div_q     <= is_div_d;
            neg_q        <= neg_d;
            rem_neg_q    <= rem_neg_d;
            done_q       <= done_d;
            alu_result_q <= alu_result_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            zero_q       <= zero_d;
            dbz_q        <= dbz_d;
`ifdef OVERFLOW_DETECT_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign aluResult = alu_result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign zero      = zero_q;
    assign divByZero = dbz_q;
`ifdef OVERFLOW_DETECT_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32): expected results are queued at issue
// and popped when done pulses; honours OVERFLOW_DETECT_EN when defined.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk, reset, start;
    logic [3:0]   aluOperation;
    logic [W-1:0] operandA, operandB;
    logic         busy, done, zero, divByZero;
    logic [W-1:0] aluResult, hi, lo;
`ifdef OVERFLOW_DETECT_EN
    logic         overflow;
`endif

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .aluOperation(aluOperation),
        .operandA(operandA),
        .operandB(operandB),
        .busy(busy),
        .done(done),
        .aluResult(aluResult),
        .hi(hi),
        .lo(lo),
        .zero(zero),
        .divByZero(divByZero)
`ifdef OVERFLOW_DETECT_EN
        ,
        .overflow(overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         zero;
        logic         dbz;
        logic         ovf;
        int           lat;
        int           bsy;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, b,
                                   input logic [W-1:0] phi, plo);
        exp_t   e;
        longint ma, mb, ps;
        logic [63:0] p;
        e.hi = phi; e.lo = plo; e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 1; e.bsy = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                e.res = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0110: begin
                e.res = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000, 4'b1001: begin
                if (op == 4'b1000) begin
                    ma = $signed(a); mb = $signed(b); ps = ma * mb; p = ps;
                end else begin
                    p = {32'b0, a} * {32'b0, b};
                end
                e.hi = p[63:32]; e.lo = p[31:0]; e.res = e.lo;
                e.lat = W + 2; e.bsy = W + 1;
            end
            4'b1010, 4'b1011: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.res = '1; e.dbz = 1'b1;
                end else begin
                    e.lat = W + 2; e.bsy = W + 1;
                    if (op == 4'b1011) begin
                        e.lo = a / b; e.hi = a % b;
                    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = a; e.hi = '0;
                    end else begin
                        e.lo = $signed(a) / $signed(b); e.hi = $signed(a) % $signed(b);
                    end
                    e.res = e.lo;
                end
            end
            default: e.res = ~(a | b);
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Issue one op at the current negedge; poke>0 re-pulses start (ADD) at that cycle.
    task automatic run(input logic [3:0] op, input logic [W-1:0] a, b, input int poke);
        exp_t e;
        int   cyc, bcnt;
        logic seen;
        e = model(op, a, b, model_hi, model_lo);
        model_hi = e.hi; model_lo = e.lo;
        sb.push_back(e);
        aluOperation = op; operandA = a; operandB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; operandA = $urandom; operandB = $urandom; aluOperation = 4'($urandom);
        cyc = 1; bcnt = 0; seen = 1'b0;
        while (!seen && cyc <= 200) begin
            if (cyc == poke) begin
                start = 1'b1; aluOperation = 4'b0010;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (busy === 1'b1) bcnt++;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check($sformatf("done_seen op=%b", op), 64'(seen), 64'd1);
        e = sb.pop_front();
        if (seen) begin
            check($sformatf("latency op=%b", op), 64'(cyc), 64'(e.lat));
            check($sformatf("busy_cycles op=%b", op), 64'(bcnt), 64'(e.bsy));
            check($sformatf("aluResult op=%b", op), 64'(aluResult), 64'(e.res));
            check($sformatf("hi op=%b", op), 64'(hi), 64'(e.hi));
            check($sformatf("lo op=%b", op), 64'(lo), 64'(e.lo));
            check($sformatf("zero op=%b", op), 64'(zero), 64'(e.zero));
            check($sformatf("divByZero op=%b", op), 64'(divByZero), 64'(e.dbz));
`ifdef OVERFLOW_DETECT_EN
            check($sformatf("overflow op=%b", op), 64'(overflow), 64'(e.ovf));
`endif
        end
        $display("op=%b A=%h B=%h -> res=%h hi=%h lo=%h zero=%b dbz=%b lat=%0d",
                 op, a, b, aluResult, hi, lo, zero, divByZero, cyc);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " aluResult"}, 64'(aluResult), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'd0);
        check({tag, " lo"}, 64'(lo), 64'd0);
        check({tag, " zero"}, 64'(zero), 64'd1);
        check({tag, " divByZero"}, 64'(divByZero), 64'd0);
`ifdef OVERFLOW_DETECT_EN
        check({tag, " overflow"}, 64'(overflow), 64'd0);
`endif
    endtask

    logic [3:0] op_list [10];
    int         dcount;

    initial begin
        op_list = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                    4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
        reset = 1'b1; start = 1'b0; aluOperation = '0; operandA = '0; operandB = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        run(4'b0010, 32'd5, 32'd7, 0);
        run(4'b0111, -32'sd3, 32'd2, 0);
        run(4'b0110, 32'd9, 32'd9, 0);
        run(4'b1000, -32'sd3, 32'd7, 0);
        run(4'b0110, 32'd9, 32'd9, 0);
        run(4'b1001, 32'hFFFF_FFFF, 32'd2, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_extra_done", 64'(done), 64'd0);
        end
        run(4'b1010, -32'sd7, 32'd2, 0);
        run(4'b1011, 32'd10, 32'd0, 0);
        run(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run(4'b1010, 32'd7, -32'sd2, 0);
        run(4'b1011, 32'hFFFF_FFFF, 32'd3, 0);
        run(4'b1010, 32'd5, 32'd0, 0);
        run(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        run(4'b0001, 32'hF000_0000, 32'h0000_000F, 0);
        run(4'b1100, 32'hF000_0000, 32'h0000_000F, 0);
        run(4'b0011, 32'h1234_5678, 32'h0000_0000, 0);
        run(4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
        run(4'b0110, 32'h8000_0000, 32'd1, 0);
        run(4'b0010, 32'd1, 32'd1, 0);
        run(4'b1000, 32'h8000_0000, 32'h8000_0000, 0);
        for (int i = 0; i < 6; i++) begin
            run(op_list[$urandom_range(0, 9)], $urandom, $urandom, 0);
        end

        // Abort a MULT with reset mid-iteration; the stray start must be ignored.
        @(negedge clk);
        aluOperation = 4'b1000; operandA = -32'sd3; operandB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            start = (cyc == 5);
            if (cyc == 5) begin
                aluOperation = 4'b0010; operandA = 32'd1; operandB = 32'd2;
            end
            reset = (cyc == 10);
            if (cyc == 9) check("abort_busy_before_reset", 64'(busy), 64'd1);
            if (done === 1'b1) dcount++;
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0;
        check("abort_no_done", 64'(dcount), 64'd0);
        check_reset_state("after_abort");
        $display("abort: reset mid-MULT, done pulses=%0d", dcount);
        model_hi = '0; model_lo = '0;
        run(4'b0010, 32'd1, 32'd1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
